decode_issue_ctrl: RTL and testbench
====================================

// Module: decode_issue_ctrl
// PURPOSE
//   Issue/hazard controller for the Decode stage. Tracks pending register-file writes in a
//   32-entry scoreboard, holds the ID stage on RAW hazards (load-use, multi-cycle results) and
//   sequences the multi-cycle Booth multiplier so only one multiply is in flight. Sits beside the
//   register file and drives the IF/ID stall and the EX-stage issue strobe.
// PARAMETERS
//   MUL_CYCLES  32  cycles the Booth multiplier needs from mul_start to result valid (>=2)
//   STALL_CW    16  width of the saturating stall-cycle performance counter
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   id_valid     in   1   ID stage holds a valid instruction
//   id_rs        in   5   source register 1 (Instruction[25:21])
//   id_rt        in   5   source register 2 (Instruction[20:16])
//   id_uses_rs   in   1   instruction reads rs
//   id_uses_rt   in   1   instruction reads rt
//   id_writes    in   1   instruction writes a register
//   id_dst       in   5   destination register (rt or rd, muxed upstream)
//   id_is_mul    in   1   instruction is a Booth multiply
//   id_flush     in   1   kill ID instruction this cycle (branch taken)
//   wb_valid     in   1   write-back writes the register file this cycle
//   wb_reg       in   5   write-back destination register
//   id_stall     out  1   hold PC and IF/ID register
//   id_issue     out  1   ID instruction advances to EX this cycle
//   mul_start    out  1   one-cycle pulse starting the Booth multiplier
//   mul_busy     out  1   multiplier occupied
//   sb_pending   out  32  scoreboard: bit n = write to $n outstanding
//   stall_cnt    out  STALL_CW  saturating count of id_stall cycles
// BEHAVIOUR
//   - Reset (rst_n=0, async): all outputs 0, scoreboard 0, state RUN, mul counter 0.
//   - id_stall/id_issue/mul_start combinational from current state + inputs; state regs on clk.
//   - raw_hit = id_valid & ((id_uses_rs & sb[id_rs] & id_rs!=0) | (id_uses_rt & sb[id_rt] & id_rt!=0)).
//   - struct_hit = id_valid & id_is_mul & (state==MUL).
//   - id_stall = (raw_hit | struct_hit) & ~id_flush.
//   - id_issue = id_valid & ~id_stall & ~id_flush. mul_start = id_issue & id_is_mul.
//   - Scoreboard: on id_issue & id_writes & id_dst!=0, set sb[id_dst] next cycle.
//     On wb_valid, clear sb[wb_reg]. Same reg set and cleared same cycle: set wins.
//     sb[0] is constant 0. id_flush never clears bits of older in-flight instructions.
//   - FSM: RUN --mul_start--> MUL (counter loaded with MUL_CYCLES-1);
//     MUL: counter decrements each cycle; at 0 -> RUN. mul_busy = (state==MUL).
//     Non-mul instructions issue freely in MUL unless raw_hit (mul dst is scoreboarded).
//     Back-to-back mul: second stalls until state returns RUN, issues in that cycle.
//   - stall_cnt increments on each id_stall cycle, saturates at all-ones, never wraps.
//   - Reset mid-multiply: FSM to RUN, scoreboard cleared; no mul_busy residue.
// CONFIGURATION
//   HAZ_WB_BYPASS_EN defined: register file is write-through; a source matching wb_reg with
//     wb_valid that cycle is treated as not pending (no stall that cycle).
//   Undefined: a pending source stalls until the cycle after its write-back clears the bit
//     (one extra stall cycle per WB-resolved hazard).
// TESTING
//   1. lw $8 issued, then add $9,$8,$1 -> id_stall=1 until wb_valid&wb_reg=8; issue next cycle
//      (same cycle with HAZ_WB_BYPASS_EN); sb_pending[8] 1 then 0.
//   2. mul to $10 with MUL_CYCLES=32 -> mul_start one pulse, mul_busy high exactly 32 cycles.
//   3. mul, mul back-to-back -> second stalls 31 cycles, issues the cycle mul_busy falls.
//   4. Write to $0 issued -> sb_pending stays 0, following reader of $0 never stalls.
//   5. Issue writing $5 same cycle as wb_reg=5 -> sb_pending[5]=1 afterwards; id_flush during
//      stall -> id_stall=0, id_issue=0, scoreboard unchanged.
//   6. rst_n low mid-multiply -> outputs 0 immediately; force stall_cnt near max -> saturates.

Source files
------------

// File: rtl/decode_issue_if.sv
// Decode/issue bundle: ID-stage instruction fields, write-back port and the hazard outputs.
// valid/ready contract: an instruction is held while id_valid=1; it advances exactly in a cycle with id_issue=1.
interface decode_issue_if #(
  parameter int STALL_CW = 16
);
  logic                id_valid;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                id_writes;
  logic [4:0]          id_dst;
  logic                id_is_mul;
  logic                id_flush;
  logic                wb_valid;
  logic [4:0]          wb_reg;
  logic                id_stall;
  logic                id_issue;
  logic                mul_start;
  logic                mul_busy;
  logic [31:0]         sb_pending;
  logic [STALL_CW-1:0] stall_cnt;
  logic                dbg_state;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writes, id_dst,
           id_is_mul, id_flush, wb_valid, wb_reg,
    input  id_stall, id_issue, mul_start, mul_busy, sb_pending, stall_cnt, dbg_state
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writes, id_dst,
           id_is_mul, id_flush, wb_valid, wb_reg,
    output id_stall, id_issue, mul_start, mul_busy, sb_pending, stall_cnt, dbg_state
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue/hazard controller: register scoreboard, RAW/structural stall, Booth mul sequencing.
// Optional HAZ_WB_BYPASS_EN: write-through register file, a source being written back this cycle is not a hazard.
module decode_issue_ctrl #(
  parameter int MUL_CYCLES = 32,
  parameter int STALL_CW   = 16
) (
  input logic          clk,
  input logic          rst_n,
  decode_issue_if.slave bus
);
  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic {S_RUN = 1'b0, S_MUL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         sb_q, sb_d;
  logic [STALL_CW-1:0] stall_cnt_q;
  logic                rs_pend, rt_pend;
  logic                raw_hit, struct_hit, stall, issue;

  always_comb begin
`ifdef HAZ_WB_BYPASS_EN
    rs_pend = sb_q[bus.id_rs] & ~(bus.wb_valid & (bus.wb_reg == bus.id_rs));
    rt_pend = sb_q[bus.id_rt] & ~(bus.wb_valid & (bus.wb_reg == bus.id_rt));
`else
    rs_pend = sb_q[bus.id_rs];
    rt_pend = sb_q[bus.id_rt];
`endif
  end

  // sb_q[0] is held at zero, so reads of $0 never see a pending write.
  assign raw_hit    = bus.id_valid & ((bus.id_uses_rs & rs_pend) | (bus.id_uses_rt & rt_pend));
  assign struct_hit = bus.id_valid & bus.id_is_mul & (state_q == S_MUL);

  // Gated by rst_n so the combinational strobes drop together with the registers on reset.
  assign stall = rst_n & (raw_hit | struct_hit) & ~bus.id_flush;
  assign issue = rst_n & bus.id_valid & ~(raw_hit | struct_hit) & ~bus.id_flush;

  assign bus.id_stall   = stall;
  assign bus.id_issue   = issue;
  assign bus.mul_start  = issue & bus.id_is_mul;
  assign bus.mul_busy   = (state_q == S_MUL);
  assign bus.sb_pending = sb_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.dbg_state  = state_q;

  // Clear first, then set, so a same-cycle issue to the written-back register stays pending.
  always_comb begin
    sb_d = sb_q;
    if (bus.wb_valid) sb_d[bus.wb_reg] = 1'b0;
    if (issue && bus.id_writes && (bus.id_dst != 5'd0)) sb_d[bus.id_dst] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (bus.mul_start) begin
          state_d = S_MUL;
          cnt_d   = CNT_LOAD;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
      if (stall && (stall_cnt_q != {STALL_CW{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed instruction sequences, expected issue cycles queued per send.
module tb_decode_issue_ctrl;
  localparam int SCW  = 4;
  localparam int MULC = 32;
  localparam int W    = 32;
`ifdef HAZ_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decode_issue_if #(.STALL_CW(SCW)) bus ();

  decode_issue_ctrl #(.MUL_CYCLES(MULC), .STALL_CW(SCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle_id();
    bus.id_valid   = 1'b0;
    bus.id_rs      = 5'd0;
    bus.id_rt      = 5'd0;
    bus.id_uses_rs = 1'b0;
    bus.id_uses_rt = 1'b0;
    bus.id_writes  = 1'b0;
    bus.id_dst     = 5'd0;
    bus.id_is_mul  = 1'b0;
    bus.id_flush   = 1'b0;
  endtask

  // Present one instruction; expect it to issue wait_n cycles after it is first presented.
  task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                      input logic wr, input logic [4:0] dst, input logic mul, input int wait_n);
    logic got;
    got = 1'b0;
    bus.id_valid   = 1'b1;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rs = urs;
    bus.id_uses_rt = urt;
    bus.id_writes  = wr;
    bus.id_dst     = dst;
    bus.id_is_mul  = mul;
    exp_q.push_back({mul, 31'(cyc + wait_n)});
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.id_issue) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=no_issue required=issue_within_%0d dst=%0d", wait_n, dst);
    end
    @(posedge clk);
    #1;
    idle_id();
  endtask

  task automatic wb_after(input int n, input logic [4:0] r);
    repeat (n) @(posedge clk);
    #1;
    bus.wb_valid = 1'b1;
    bus.wb_reg   = r;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
  endtask

  task automatic wait_mul_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.mul_busy) break;
    end
    @(posedge clk);
    #1;
    check("mul_idle", 32'(bus.mul_busy), 32'd0);
  endtask

  // Monitor: every issue must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.id_issue) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual=issue required=none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("issue_cycle", {1'b0, 31'(cyc)}, {1'b0, e[30:0]});
        check("mul_start", 32'(bus.mul_start), 32'(e[31]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_id();
    bus.wb_valid = 1'b0;
    bus.wb_reg   = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sb", bus.sb_pending, 32'd0);
    check("rst_busy", 32'(bus.mul_busy), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on $8
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 0);
    check("sb_after_lw", bus.sb_pending, 32'h0000_0100);
    fork
      send(5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, BYP ? 3 : 4);
      wb_after(3, 5'd8);
    join
    check("sb_after_wb8", bus.sb_pending, 32'd0);
    check("stall_cnt_t1", 32'(bus.stall_cnt), BYP ? 32'd3 : 32'd4);

    // Single multiply: busy exactly MUL_CYCLES
    send(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd10, 1'b1, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.mul_busy) break;
      n++;
    end
    check("mul_busy_len", 32'(n), 32'd32);
    @(posedge clk);
    #1;
    check("sb_mul10", bus.sb_pending, 32'h0000_0400);
    wb_after(0, 5'd10);
    check("sb_after_wb10", bus.sb_pending, 32'd0);

    // Back-to-back multiplies, then a free issue and a RAW on the mul result
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1, 0);
    @(posedge clk);
    #1;
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 31);
    send(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd13, 1'b0, 0);
    check("busy_during_free_issue", 32'(bus.mul_busy), 32'd1);
    check("sb_11_12_13", bus.sb_pending, 32'h0000_3800);
    check("stall_cnt_sat", 32'(bus.stall_cnt), 32'd15);
    fork
      send(5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, BYP ? 4 : 5);
      wb_after(4, 5'd12);
    join
    wb_after(0, 5'd11);
    wb_after(0, 5'd13);
    check("sb_after_t3", bus.sb_pending, 32'd0);
    wait_mul_idle();
    check("stall_cnt_no_wrap", 32'(bus.stall_cnt), 32'd15);

    // Writes to $0 and readers of $0
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 0);
    check("sb_write_r0", bus.sb_pending, 32'd0);
    send(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 0);

    // Issue to $5 while $5 is written back: set wins
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd5;
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 0);
    bus.wb_valid = 1'b0;
    check("sb_set_wins", bus.sb_pending, 32'h0000_0020);

    // Flush during a stall
    bus.id_valid   = 1'b1;
    bus.id_rs      = 5'd5;
    bus.id_uses_rs = 1'b1;
    @(negedge clk);
    check("stall_on_r5", 32'(bus.id_stall), 32'd1);
    check("no_issue_on_r5", 32'(bus.id_issue), 32'd0);
    @(posedge clk);
    #1;
    bus.id_flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 32'(bus.id_stall), 32'd0);
    check("flush_issue", 32'(bus.id_issue), 32'd0);
    @(posedge clk);
    #1;
    idle_id();
    check("sb_after_flush", bus.sb_pending, 32'h0000_0020);
    wb_after(0, 5'd5);
    check("sb_after_wb5", bus.sb_pending, 32'd0);

    // Reset in the middle of a multiply
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd14, 1'b1, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("busy_before_rst", 32'(bus.mul_busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.id_valid  = 1'b1;
    bus.id_is_mul = 1'b1;
    #1;
    check("rst_mid_issue", 32'(bus.id_issue), 32'd0);
    check("rst_mid_mul_start", 32'(bus.mul_start), 32'd0);
    check("rst_mid_stall", 32'(bus.id_stall), 32'd0);
    check("rst_mid_busy", 32'(bus.mul_busy), 32'd0);
    check("rst_mid_sb", bus.sb_pending, 32'd0);
    check("rst_mid_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    idle_id();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh stall count after reset, then saturate again
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 0);
    fork
      send(5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, BYP ? 2 : 3);
      wb_after(2, 5'd8);
    join
    check("stall_cnt_post_rst", 32'(bus.stall_cnt), BYP ? 32'd2 : 32'd3);
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd20, 1'b1, 0);
    @(posedge clk);
    #1;
    send(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd21, 1'b1, 31);
    check("stall_cnt_resat", 32'(bus.stall_cnt), 32'd15);
    wait_mul_idle();
    wb_after(0, 5'd20);
    wb_after(0, 5'd21);
    check("sb_final", bus.sb_pending, 32'd0);

    repeat (2) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
